// File: rtl/write_buffer_pkg.sv
// Shared types for the posted-write buffer: FSM states, FIFO entry layout
// and the default buffer depth.
package write_buffer_pkg;

  localparam int WB_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Posted-write FIFO: in-order entry storage with wrapping pointers, an
// occupancy count and a youngest-entry address lookup for read hits.
module wb_fifo
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic [29:0] lookup_word,
  output logic [31:0] head_addr,
  output logic [31:0] head_data,
  output logic        full,
  output logic        fifo_empty,
  output logic        hit,
  output logic [31:0] hit_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t              entry_q [DEPTH];
  wb_entry_t              entry_d [DEPTH];
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       scan_idx;

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      entry_d[tail_q] = '{addr: push_addr, data: push_data};
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk from oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = PTR_W'(32'(head_q) + i);
      if (valid_q[scan_idx] && (entry_q[scan_idx].addr[31:2] == lookup_word)) begin
        hit      = 1'b1;
        hit_data = entry_q[scan_idx].data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset; valid bits alone decide what is live.
  always_ff @(posedge clock) begin
    entry_q <= entry_d;
  end

  assign head_addr  = entry_q[head_q].addr;
  assign head_data  = entry_q[head_q].data;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);

endmodule

// File: rtl/write_buffer.sv
// Write buffer between the L2 cache and memory: posts writes into a FIFO,
// serves read hits from it and arbitrates the memory port between reads and drains.
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_wdata,
  input  logic        up_read,
  input  logic        up_write,
  output logic [31:0] up_rdata,
  output logic        up_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        empty
);

  wb_state_e   state_q, state_d;
  logic        up_ready_q, up_ready_d;
  logic [31:0] up_rdata_q, up_rdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        rd_req, wr_req, read_hit, read_miss, push, pop;
  logic        full, fifo_empty, hit;
  logic [31:0] hit_data, head_addr, head_data;

  // Requests seen while an acknowledge is on the wire are the old request.
  assign rd_req    = !up_ready_q && up_read;
  assign wr_req    = !up_ready_q && up_write && !up_read;
  assign read_hit  = rd_req && hit && (state_q != RD);
  assign read_miss = rd_req && !hit;
  assign push      = wr_req && !full;
  assign pop       = (state_q == WR) && mem_ready;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_addr  (up_addr),
    .push_data  (up_wdata),
    .pop        (pop),
    .lookup_word(up_addr[31:2]),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .fifo_empty (fifo_empty),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  // A drain is not started in an acknowledge cycle, so a read issued right
  // after a posted write can claim the memory port first.
  always_comb begin
    state_d     = state_q;
    up_ready_d  = 1'b0;
    up_rdata_d  = up_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (read_hit) begin
      up_ready_d = 1'b1;
      up_rdata_d = hit_data;
    end else if (push) begin
      up_ready_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (read_miss) begin
          state_d    = RD;
          mem_read_d = 1'b1;
          mem_addr_d = up_addr;
        end else if (!fifo_empty && !up_ready_q) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
        end
      end
      WR: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_write_d = 1'b0;
        end
      end
      RD: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
          up_rdata_d = mem_rdata;
          up_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      up_ready_q  <= 1'b0;
      up_rdata_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      up_ready_q  <= up_ready_d;
      up_rdata_q  <= up_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign up_ready  = up_ready_q;
  assign up_rdata  = up_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign empty     = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: posted writes, read hits and misses,
// full-buffer stall and reset mid-drain, against a simple memory responder.
module tb_write_buffer;

  logic        clock;
  logic        reset;
  logic [31:0] up_addr, up_wdata, up_rdata;
  logic        up_read, up_write, up_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_ready;
  logic        empty;

  int          compared;
  int          mismatched;
  int          cyc;
  logic        memEnable;
  logic        memReadEver;
  logic [31:0] memReadData;
  logic [31:0] logAddr[$];
  logic [31:0] logData[$];
  logic [7:0]  logKind[$];

  write_buffer #(.DEPTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .up_addr  (up_addr),
    .up_wdata (up_wdata),
    .up_read  (up_read),
    .up_write (up_write),
    .up_rdata (up_rdata),
    .up_ready (up_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .empty    (empty)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign mem_rdata = memReadData;

  // Memory model: answers any request one cycle after it appears, and logs
  // every transaction it acknowledges in issue order.
  initial mem_ready = 1'b0;
  always @(posedge clock) begin
    #2;
    if (mem_read === 1'b1) memReadEver = 1'b1;
    if (memEnable && (mem_read || mem_write) && !mem_ready) begin
      mem_ready = 1'b1;
      logAddr.push_back(mem_addr);
      logData.push_back(mem_wdata);
      logKind.push_back(mem_read ? "R" : "W");
    end else begin
      mem_ready = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    up_read  = rd;
    up_write = wr;
    up_addr  = addr;
    up_wdata = data;
  endtask

  task automatic waitReady(input int maxCycles, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      if (!done) begin
        tick();
        if (up_ready === 1'b1) begin
          cycles = i;
          done   = 1'b1;
        end
      end
    end
  endtask

  task automatic endRequest(input string tag);
    up_read  = 1'b0;
    up_write = 1'b0;
    tick();
    checkOutput({tag, "_pulse"}, {31'b0, up_ready}, 32'd0);
  endtask

  task automatic waitEmpty(input string tag, input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (empty !== 1'b1) tick();
    end
    checkOutput(tag, {31'b0, empty}, 32'd1);
  endtask

  task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
    int c;
    applyStimulus(1'b0, 1'b1, addr, data);
    waitReady(8, c);
    checkOutput({tag, "_lat"}, c, 32'd1);
    endRequest(tag);
  endtask

  task automatic doRead(input string tag, input logic [31:0] addr,
                        input logic [31:0] expData, input int expLat);
    int c;
    applyStimulus(1'b1, 1'b0, addr, 32'd0);
    waitReady(8, c);
    checkOutput({tag, "_lat"}, c, expLat);
    checkOutput({tag, "_data"}, up_rdata, expData);
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
    logKind.delete();
    memReadEver = 1'b0;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset       = 1'b1;
    memEnable   = 1'b0;
    memReadData = 32'd0;
    memReadEver = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state and quiet idle.
    tick();
    tick();
    checkOutput("rst_up_ready", {31'b0, up_ready}, 32'd0);
    checkOutput("rst_up_rdata", up_rdata, 32'd0);
    checkOutput("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_empty", {31'b0, empty}, 32'd1);
    reset     = 1'b0;
    memEnable = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("idle_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    checkOutput("idle_empty", {31'b0, empty}, 32'd1);
    checkOutput("idle_no_mem", logAddr.size(), 32'd0);

    // Read hit on a freshly posted write, no memory read.
    memEnable = 1'b0;
    clearLog();
    doWrite("hit_wr", 32'h10, 32'hAAAA0001);
    doRead("hit_rd", 32'h10, 32'hAAAA0001, 1);
    checkOutput("hit_no_memrd", {31'b0, memReadEver}, 32'd0);
    checkOutput("hit_drain_wr", {31'b0, mem_write}, 32'd1);
    checkOutput("hit_drain_addr", mem_addr, 32'h10);
    checkOutput("hit_drain_data", mem_wdata, 32'hAAAA0001);
    endRequest("hit_rd");
    memEnable = 1'b1;
    waitEmpty("hit_empty", 20);
    checkOutput("hit_log_n", logAddr.size(), 32'd1);
    checkOutput("hit_log_data", logData[0], 32'hAAAA0001);

    // Duplicate addresses: youngest data wins, both drain in order.
    memEnable = 1'b0;
    clearLog();
    doWrite("dup_wr1", 32'h20, 32'd1);
    doWrite("dup_wr2", 32'h20, 32'd2);
    doRead("dup_rd", 32'h20, 32'd2, 1);
    endRequest("dup_rd");
    memEnable = 1'b1;
    waitEmpty("dup_empty", 30);
    checkOutput("dup_log_n", logAddr.size(), 32'd2);
    checkOutput("dup_first", logData[0], 32'd1);
    checkOutput("dup_second", logData[1], 32'd2);

    // Full buffer: fifth write stalls until the first drain pops the head.
    memEnable = 1'b0;
    clearLog();
    for (int i = 0; i < 4; i++) begin
      doWrite($sformatf("full_wr%0d", i), 32'(32'h100 + 4 * i), 32'(32'h11 + i));
    end
    applyStimulus(1'b0, 1'b1, 32'h110, 32'h15);
    waitReady(4, cyc);
    checkOutput("full_stall", cyc, 32'hFFFF_FFFF);
    memEnable = 1'b1;
    waitReady(10, cyc);
    checkOutput("full_release_lat", cyc, 32'd2);
    checkOutput("full_release_pops", logAddr.size(), 32'd1);
    endRequest("full_wr4");
    waitEmpty("full_empty", 60);
    checkOutput("full_log_n", logAddr.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("full_order%0d", i), logAddr[i], 32'(32'h100 + 4 * i));
    end
    checkOutput("full_last_data", logData[4], 32'h15);

    // Read miss overtakes a pending drain.
    clearLog();
    memReadData = 32'hDEAD;
    doWrite("miss_wr", 32'h40, 32'h4444);
    doRead("miss_rd", 32'h80, 32'hDEAD, 2);
    endRequest("miss_rd");
    waitEmpty("miss_empty", 20);
    checkOutput("miss_log_n", logAddr.size(), 32'd2);
    checkOutput("miss_first_kind", {24'b0, logKind[0]}, 32'h52);
    checkOutput("miss_first_addr", logAddr[0], 32'h80);
    checkOutput("miss_then_kind", {24'b0, logKind[1]}, 32'h57);
    checkOutput("miss_then_addr", logAddr[1], 32'h40);

    // Reset while draining three buffered writes.
    memEnable = 1'b0;
    clearLog();
    doWrite("rstx_wr0", 32'h200, 32'h1);
    doWrite("rstx_wr1", 32'h204, 32'h2);
    doWrite("rstx_wr2", 32'h208, 32'h3);
    checkOutput("rstx_in_wr", {31'b0, mem_write}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("rstx_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    checkOutput("rstx_empty", {31'b0, empty}, 32'd1);
    checkOutput("rstx_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    checkOutput("rstx_no_ready", {31'b0, up_ready}, 32'd0);
    memEnable   = 1'b1;
    memReadData = 32'h5555;
    doRead("rstx_rd", 32'h204, 32'h5555, 2);
    endRequest("rstx_rd");
    tick();
    tick();
    tick();
    tick();
    checkOutput("rstx_log_n", logAddr.size(), 32'd1);
    checkOutput("rstx_log_kind", {24'b0, logKind[0]}, 32'h52);
    checkOutput("rstx_log_addr", logAddr[0], 32'h204);

    // Read and write together behave as a read and push nothing.
    memEnable = 1'b0;
    clearLog();
    doWrite("both_wr", 32'h300, 32'h77);
    applyStimulus(1'b1, 1'b1, 32'h300, 32'h99);
    waitReady(8, cyc);
    checkOutput("both_lat", cyc, 32'd1);
    checkOutput("both_data", up_rdata, 32'h77);
    endRequest("both");
    memEnable = 1'b1;
    waitEmpty("both_empty", 20);
    checkOutput("both_log_n", logAddr.size(), 32'd1);
    checkOutput("both_log_data", logData[0], 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
